// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared types and constants for the SPI frame engine
// Purpose : FSM state enum, command/byte constants, mode field positions and
//           the command-byte address range check.
// Ports   : none (package).
package spi_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CMD    = 2'd1,
      ST_DATA   = 2'd2,
      ST_IGNORE = 2'd3
   } state_t;

   localparam int CMD_WR_BIT = 7;
   localparam int BYTE_W     = 8;
   // mode input is {CPOL,CPHA}
   localparam int MODE_CPOL  = 1;
   localparam int MODE_CPHA  = 0;

   // A command is valid only when no address bit above the register space is set.
   function automatic logic cmd_valid(input logic [BYTE_W-1:0] cmd, input int addr_w);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < CMD_WR_BIT; i++) begin
         if (i >= addr_w && cmd[i]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// rtl/spi_edge_detect.sv - SCLK sample/shift edge pulse generator
// Purpose : compares spi_clk with its previous-cycle value and classifies the
//           change as leading (leaving CPOL) or trailing (returning to CPOL),
//           then maps it to sample/shift according to CPHA.
// Ports   : clk_i, rst_i (sync, active-high), ena_i, spi_clk_i, cpol_i, cpha_i,
//           sample_edge_o, shift_edge_o (single-cycle pulses).
module spi_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ena_i,
   input  logic spi_clk_i,
   input  logic cpol_i,
   input  logic cpha_i,
   output logic sample_edge_o,
   output logic shift_edge_o
);

   logic sclk_q;
   logic leading;
   logic trailing;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_q <= 1'b0;
      end else if (ena_i) begin
         sclk_q <= spi_clk_i;
      end
   end

   assign leading  = ena_i && (sclk_q == cpol_i) && (spi_clk_i != cpol_i);
   assign trailing = ena_i && (sclk_q != cpol_i) && (spi_clk_i == cpol_i);

   assign sample_edge_o = cpha_i ? trailing : leading;
   assign shift_edge_o  = cpha_i ? leading  : trailing;

endmodule

// File: rtl/spi_frame_engine.sv
// rtl/spi_frame_engine.sv - SPI slave frame engine driving a register port
// Purpose : decodes a command byte (bit7 write, low bits address) followed by
//           data bytes, issuing one-cycle register write/read strobes and
//           returning read data MSB first on spi_miso.
// Ports   : clk, rst (sync, active-high), ena, spi_cs_n, spi_clk, spi_mosi,
//           mode {CPOL,CPHA}, spi_miso, reg_addr, reg_wdata, reg_wr, reg_rd,
//           reg_rdata, busy.
// Config  : define SPI_FRAME_ENGINE_AUTOINC_EN for burst mode (address
//           auto-increment with repeated strobes on every further data byte).
module spi_frame_engine
   import spi_frame_pkg::*;
#(
   parameter int ADDR_W   = 3,
   parameter int MIN_HALF = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   input  logic [1:0]        mode,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);

   state_t              state_q;
   logic [1:0]          mode_q;
   logic                cs_prev_q;
   logic [2:0]          cnt_q;
   logic [BYTE_W-2:0]   rx_q;
   logic [BYTE_W-1:0]   sh_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [BYTE_W-1:0]   wdata_q;
   logic                wr_q;
   logic                rd_q;
   logic                rd_dly_q;
   logic                wr_cmd_q;
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
   logic                first_q;
`endif

   logic                sample_edge;
   logic                shift_edge;
   logic                cs_fall;
   logic [BYTE_W-1:0]   rx_d;

   spi_edge_detect u_edge (
      .clk_i         (clk),
      .rst_i         (rst),
      .ena_i         (ena),
      .spi_clk_i     (spi_clk),
      .cpol_i        (mode_q[MODE_CPOL]),
      .cpha_i        (mode_q[MODE_CPHA]),
      .sample_edge_o (sample_edge),
      .shift_edge_o  (shift_edge)
   );

   // cs_prev_q resets low so a cs_n already low at reset release is not a fall.
   assign cs_fall = cs_prev_q && !spi_cs_n;
   assign rx_d    = {rx_q, spi_mosi};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= 2'b00;
         cs_prev_q <= 1'b0;
         cnt_q     <= 3'd0;
         rx_q      <= '0;
         sh_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         rd_dly_q  <= 1'b0;
         wr_cmd_q  <= 1'b0;
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
         first_q   <= 1'b0;
`endif
      end else if (!ena) begin
         wr_q <= 1'b0;
         rd_q <= 1'b0;
      end else begin
         cs_prev_q <= spi_cs_n;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         rd_dly_q  <= rd_q;
         if (spi_cs_n) begin
            // Deselect wins over any byte completing this cycle.
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state_q <= ST_CMD;
                     mode_q  <= mode;
                     cnt_q   <= 3'd0;
                     sh_q    <= '0;
                  end
               end
               ST_CMD: begin
                  if (sample_edge) begin
                     cnt_q <= cnt_q + 3'd1;
                     rx_q  <= rx_d[BYTE_W-2:0];
                     if (cnt_q == 3'd7) begin
                        if (cmd_valid(rx_d, ADDR_W)) begin
                           state_q  <= ST_DATA;
                           addr_q   <= rx_d[ADDR_W-1:0];
                           wr_cmd_q <= rx_d[CMD_WR_BIT];
                           rd_q     <= !rx_d[CMD_WR_BIT];
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
                           first_q  <= 1'b1;
`endif
                        end else begin
                           state_q <= ST_IGNORE;
                        end
                     end
                  end
               end
               ST_DATA: begin
                  // No shift at bit count 0: that edge belongs to the previous
                  // byte (CPHA=0) or precedes the first data sample (CPHA=1).
                  if (shift_edge && cnt_q != 3'd0) begin
                     sh_q <= {sh_q[BYTE_W-2:0], 1'b0};
                  end
                  if (sample_edge) begin
                     cnt_q <= cnt_q + 3'd1;
                     rx_q  <= rx_d[BYTE_W-2:0];
                     if (cnt_q == 3'd7) begin
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
                        first_q <= 1'b0;
                        if (wr_cmd_q) begin
                           if (!first_q) addr_q <= addr_q + ADDR_W'(1);
                           wdata_q <= rx_d;
                           wr_q    <= 1'b1;
                        end else begin
                           addr_q <= addr_q + ADDR_W'(1);
                           rd_q   <= 1'b1;
                        end
`else
                        if (wr_cmd_q) begin
                           wdata_q <= rx_d;
                           wr_q    <= 1'b1;
                        end
                        state_q <= ST_IGNORE;
`endif
                     end
                  end
               end
               default: begin
               end
            endcase
         end
         // Read data arrives the cycle after reg_rd and overrides any shift.
         if (rd_dly_q) sh_q <= reg_rdata;
      end
   end

   assign spi_miso  = (state_q == ST_DATA && !spi_cs_n) ? sh_q[BYTE_W-1] : 1'b0;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_wr    = wr_q;
   assign reg_rd    = rd_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_engine.sv
// tb/tb_spi_frame_engine.sv - scoreboard bench for spi_frame_engine
module tb_spi_frame_engine;

   localparam int ADDR_W = 3;
   localparam int H      = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              ena;
   logic              spi_cs_n;
   logic              spi_clk;
   logic              spi_mosi;
   logic [1:0]        mode;
   logic              spi_miso;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_wr;
   logic              reg_rd;
   logic [7:0]        reg_rdata;
   logic              busy;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] tx_bytes[4];
   logic [7:0] rx_bytes[4];
   logic [7:0] tmp;

   spi_frame_engine #(.ADDR_W(ADDR_W), .MIN_HALF(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .spi_cs_n  (spi_cs_n),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .mode      (mode),
      .spi_miso  (spi_miso),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Monitor: every strobe pops one expected transaction.
   always @(negedge clk) begin
      if (reg_wr || reg_rd) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe wr=%0b rd=%0b addr=%0h wdata=%0h expected=none",
                     reg_wr, reg_rd, reg_addr, reg_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobe_wr", 32'(reg_wr), 32'(mon_e.wr));
            check("strobe_rd", 32'(reg_rd), 32'(!mon_e.wr));
            check("strobe_addr", 32'(reg_addr), 32'(mon_e.addr));
            if (mon_e.wr) check("strobe_wdata", 32'(reg_wdata), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d);
      exp_t e;
      e.wr = wr; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
      logic cpol, cpha;
      cpol = mode[1];
      cpha = mode[0];
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            spi_mosi = b[i];
            repeat (H) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_clk = ~cpol;
            repeat (H) @(negedge clk);
            spi_clk = cpol;
         end else begin
            repeat (H) @(negedge clk);
            spi_clk = ~cpol;
            spi_mosi = b[i];
            repeat (H) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_clk = cpol;
         end
      end
   endtask

   task automatic run_frame(input logic [1:0] m, input int nbytes, input int last_bits);
      logic [7:0] r;
      mode = m;
      spi_clk = m[1];
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      check("busy_in_frame", 32'(busy), 32'd1);
      for (int k = 0; k < nbytes; k++) begin
         spi_byte(tx_bytes[k], (k == nbytes - 1) ? last_bits : 8, r);
         rx_bytes[k] = r;
      end
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (H) @(negedge clk);
      check("busy_after_frame", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      mode = 2'b00; reg_rdata = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_miso", 32'(spi_miso), 32'd0);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_wdata", 32'(reg_wdata), 32'd0);
      check("rst_wr", 32'(reg_wr), 32'd0);
      check("rst_rd", 32'(reg_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Mode 0 write 0x5A to address 3.
      tx_bytes[0] = 8'h83; tx_bytes[1] = 8'h5A;
      push(1'b1, 3'd3, 8'h5A);
      run_frame(2'b00, 2, 8);

      // Mode 3 read of address 5 returning 0xC3.
      reg_rdata = 8'hC3;
      tx_bytes[0] = 8'h05; tx_bytes[1] = 8'h00;
      push(1'b0, 3'd5, 8'h00);
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
      push(1'b0, 3'd6, 8'h00);
`endif
      run_frame(2'b11, 2, 8);
      check("rd_miso_cmd", 32'(rx_bytes[0]), 32'h00);
      check("rd_miso_data", 32'(rx_bytes[1]), 32'hC3);

      // Mode 0 read of address 2 returning 0x96.
      reg_rdata = 8'h96;
      tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h00;
      push(1'b0, 3'd2, 8'h00);
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
      push(1'b0, 3'd3, 8'h00);
`endif
      run_frame(2'b00, 2, 8);
      check("rd0_miso_data", 32'(rx_bytes[1]), 32'h96);

      // Mode 1 invalid address: no strobes, MISO silent.
      reg_rdata = 8'hFF;
      tx_bytes[0] = 8'hC0; tx_bytes[1] = 8'h11;
      run_frame(2'b01, 2, 8);
      check("ign_miso0", 32'(rx_bytes[0]), 32'h00);
      check("ign_miso1", 32'(rx_bytes[1]), 32'h00);

      // Abort after 12 bits, then a full write to address 1.
      tx_bytes[0] = 8'h81; tx_bytes[1] = 8'hFF;
      run_frame(2'b00, 2, 4);
      tx_bytes[0] = 8'h81; tx_bytes[1] = 8'h22;
      push(1'b1, 3'd1, 8'h22);
      run_frame(2'b00, 2, 8);

      // Mode 2 three-byte write.
      tx_bytes[0] = 8'h87; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'h02;
      push(1'b1, 3'd7, 8'h01);
`ifdef SPI_FRAME_ENGINE_AUTOINC_EN
      push(1'b1, 3'd0, 8'h02);
`endif
      run_frame(2'b10, 3, 8);

      // Reset mid-write after 4 bits; cs_n stays low so no new frame may start.
      mode = 2'b00; spi_clk = 1'b0;
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      spi_byte(8'h83, 4, tmp);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_miso", 32'(spi_miso), 32'd0);
      check("midrst_addr", 32'(reg_addr), 32'd0);
      check("midrst_wdata", 32'(reg_wdata), 32'd0);
      check("midrst_wr", 32'(reg_wr), 32'd0);
      check("midrst_rd", 32'(reg_rd), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      spi_byte(8'h83, 8, tmp);
      spi_byte(8'h44, 8, tmp);
      check("no_frame_after_rst_busy", 32'(busy), 32'd0);
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b1;

      repeat (20) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
